// File: rtl/ser_frame_pkg.sv
// rtl/ser_frame_pkg.sv - FSM encoding, direction names and parity helper for ser_frame_rx
package ser_frame_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DATA      = 3'd1;
  localparam logic [2:0] PARITY    = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  localparam string DIR_LEFT  = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";

  // Words are zero-extended to this width; zero padding leaves the parity unchanged.
  localparam int PARITY_MAX_W = 64;

  function automatic logic parity_ok(input logic [PARITY_MAX_W-1:0] word,
                                     input logic bit_in,
                                     input logic odd);
    return ((^word) ^ bit_in) == odd;
  endfunction

endpackage

// File: rtl/ser_frame_rx_hold_buf.sv
// rtl/ser_frame_rx_hold_buf.sv - one-entry valid/ready holding register for received words
module rx_hold_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  sclr,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  drop
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  w_xfer;

  assign w_xfer = r_valid & data_ready;
  assign drop   = load & r_valid & ~data_ready;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (sclr) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (load && (!r_valid || w_xfer)) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;

endmodule

// File: rtl/ser_frame_rx.sv
// rtl/ser_frame_rx.sv - framed serial word receiver (start, data, optional parity, stop)
module ser_frame_rx
  import ser_frame_pkg::*;
#(
  parameter int    DATA_WIDTH      = 8,
  parameter bit    PARITY_EN       = 1'b1,
  parameter bit    PARITY_ODD      = 1'b0,
  parameter string SHIFT_DIRECTION = "LEFT"
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  enable,
  input  logic                  serial_in,
  input  logic                  sclr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CW        = $clog2(DATA_WIDTH + 1);
  localparam bit LSB_FIRST = (SHIFT_DIRECTION == DIR_RIGHT);

  logic [2:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_par_ok;
  logic                  r_parity_err;
  logic                  r_frame_err;
  logic                  r_overrun;

  logic [DATA_WIDTH-1:0] w_acc_shift;
  logic                  w_par_ok;
  logic                  w_good;
  logic                  w_drop;

  always_comb begin
    w_acc_shift = r_acc;
    if (LSB_FIRST) w_acc_shift = {serial_in, r_acc[DATA_WIDTH-1:1]};
    else           w_acc_shift = {r_acc[DATA_WIDTH-2:0], serial_in};
  end

  assign w_par_ok = PARITY_EN ? r_par_ok : 1'b1;
  assign w_good   = enable & (r_state == STOP) & serial_in & w_par_ok;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_par_ok     <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (sclr) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_par_ok     <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_drop) r_overrun <= 1'b1;
      if (enable) begin
        case (r_state)
          IDLE: begin
            if (!serial_in) begin
              r_state <= DATA;
              r_cnt   <= '0;
            end
          end
          DATA: begin
            r_acc <= w_acc_shift;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(DATA_WIDTH - 1)) r_state <= PARITY_EN ? PARITY : STOP;
          end
          PARITY: begin
            r_par_ok <= parity_ok(PARITY_MAX_W'(r_acc), serial_in, PARITY_ODD);
            r_state  <= STOP;
          end
          STOP: begin
            // A low stop bit is a framing error regardless of parity.
            if (!serial_in) begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_IDLE;
            end else begin
              if (!w_par_ok) r_parity_err <= 1'b1;
              r_state <= IDLE;
            end
          end
          WAIT_IDLE: begin
            if (serial_in) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  rx_hold_buf #(.DATA_WIDTH(DATA_WIDTH)) u_hold_buf (
    .clock      (clock),
    .aclr_n     (aclr_n),
    .sclr       (sclr),
    .load       (w_good),
    .load_data  (r_acc),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .drop       (w_drop)
  );

  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_ser_frame_rx.sv
// tb/tb_ser_frame_rx.sv - scoreboard bench for ser_frame_rx in LEFT/parity and RIGHT/no-parity builds
module tb_ser_frame_rx;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic aclr_n, sclr;
  logic       l_en, l_sin, l_rdy;
  logic [7:0] l_dout;
  logic       l_dv, l_perr, l_ferr, l_ovr, l_busy;
  logic       r_en, r_sin, r_rdy;
  logic [7:0] r_dout;
  logic       r_dv, r_perr, r_ferr, r_ovr, r_busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  ser_frame_rx #(.DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .SHIFT_DIRECTION("LEFT")) dut_l (
    .clock(clock), .aclr_n(aclr_n), .enable(l_en), .serial_in(l_sin), .sclr(sclr),
    .data_out(l_dout), .data_valid(l_dv), .data_ready(l_rdy),
    .parity_err(l_perr), .frame_err(l_ferr), .overrun(l_ovr), .busy(l_busy)
  );

  ser_frame_rx #(.DATA_WIDTH(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .SHIFT_DIRECTION("RIGHT")) dut_r (
    .clock(clock), .aclr_n(aclr_n), .enable(r_en), .serial_in(r_sin), .sclr(sclr),
    .data_out(r_dout), .data_valid(r_dv), .data_ready(r_rdy),
    .parity_err(r_perr), .frame_err(r_ferr), .overrun(r_ovr), .busy(r_busy)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  // Frame on dut_l, MSB first; expected parity computed here from the word.
  task automatic send_l(input logic [7:0] w, input logic par_flip, input logic stop_bit,
                        input logic rdy_on_stop);
    logic [10:0] bits;
    bits = {1'b0, w, (^w) ^ par_flip, stop_bit};
    for (int i = 10; i >= 0; i--) begin
      l_sin = bits[i];
      l_en  = 1'b1;
      if (i == 0 && rdy_on_stop) l_rdy = 1'b1;
      tick();
    end
    if (rdy_on_stop) l_rdy = 1'b0;
  endtask

  task automatic test_reset();
    aclr_n = 1'b0; sclr = 1'b0;
    l_en = 1'b0; l_sin = 1'b1; l_rdy = 1'b0;
    r_en = 1'b0; r_sin = 1'b1; r_rdy = 1'b0;
    tick();
    total++;
    if ({l_dout, l_dv, l_perr, l_ferr, l_ovr, l_busy} !== 13'h0) begin
      bad++; $display("FAIL reset_l got=%h exp=0", {l_dout, l_dv, l_perr, l_ferr, l_ovr, l_busy});
    end
    total++;
    if ({r_dout, r_dv, r_perr, r_ferr, r_ovr, r_busy} !== 13'h0) begin
      bad++; $display("FAIL reset_r got=%h exp=0", {r_dout, r_dv, r_perr, r_ferr, r_ovr, r_busy});
    end
    aclr_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    exp_q.push_back(8'hA5);
    send_l(8'hA5, 1'b0, 1'b1, 1'b0);
    total++;
    if (l_dv !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", l_dv); end
    exp_w = exp_q.pop_front();
    total++;
    if (l_dout !== exp_w) begin bad++; $display("FAIL basic_data got=%h exp=%h", l_dout, exp_w); end
    total++;
    if (l_busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", l_busy); end
    l_rdy = 1'b1;
    tick();
    l_rdy = 1'b0;
    total++;
    if (l_dv !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", l_dv); end
  endtask

  task automatic test_parity_err();
    send_l(8'hA5, 1'b1, 1'b1, 1'b0);
    total++;
    if ({l_perr, l_dv, l_busy} !== 3'b100) begin
      bad++; $display("FAIL parity_pulse got=%b exp=100", {l_perr, l_dv, l_busy});
    end
    tick();
    total++;
    if (l_perr !== 1'b0) begin bad++; $display("FAIL parity_one_cycle got=%b exp=0", l_perr); end
  endtask

  task automatic test_frame_err();
    send_l(8'hA5, 1'b0, 1'b0, 1'b0);
    total++;
    if ({l_ferr, l_busy, l_dv} !== 3'b110) begin
      bad++; $display("FAIL frame_pulse got=%b exp=110", {l_ferr, l_busy, l_dv});
    end
    tick();
    total++;
    if ({l_ferr, l_busy} !== 2'b01) begin
      bad++; $display("FAIL frame_wait got=%b exp=01", {l_ferr, l_busy});
    end
    l_sin = 1'b1; l_en = 1'b0;
    tick();
    total++;
    if (l_busy !== 1'b1) begin bad++; $display("FAIL frame_gated got=%b exp=1", l_busy); end
    l_en = 1'b1;
    tick();
    total++;
    if (l_busy !== 1'b0) begin bad++; $display("FAIL frame_idle got=%b exp=0", l_busy); end
  endtask

  task automatic test_overrun();
    exp_q.push_back(8'hA5);
    send_l(8'hA5, 1'b0, 1'b1, 1'b0);
    send_l(8'h3C, 1'b0, 1'b1, 1'b0);
    exp_w = exp_q.pop_front();
    total++;
    if (l_dout !== exp_w) begin bad++; $display("FAIL overrun_data got=%h exp=%h", l_dout, exp_w); end
    total++;
    if ({l_dv, l_ovr} !== 2'b11) begin
      bad++; $display("FAIL overrun_flag got=%b exp=11", {l_dv, l_ovr});
    end
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    total++;
    if ({l_dv, l_ovr} !== 2'b00) begin
      bad++; $display("FAIL overrun_sclr got=%b exp=00", {l_dv, l_ovr});
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(8'h81);
    send_l(8'h81, 1'b0, 1'b1, 1'b0);
    exp_w = exp_q.pop_front();
    total++;
    if ({l_dv, l_dout} !== {1'b1, exp_w}) begin
      bad++; $display("FAIL b2b_first got=%b/%h exp=1/%h", l_dv, l_dout, exp_w);
    end
    exp_q.push_back(8'h7F);
    send_l(8'h7F, 1'b0, 1'b1, 1'b1);
    exp_w = exp_q.pop_front();
    total++;
    if ({l_dv, l_dout} !== {1'b1, exp_w}) begin
      bad++; $display("FAIL b2b_swap got=%b/%h exp=1/%h", l_dv, l_dout, exp_w);
    end
    total++;
    if (l_ovr !== 1'b0) begin bad++; $display("FAIL b2b_no_overrun got=%b exp=0", l_ovr); end
    l_rdy = 1'b1;
    tick();
    l_rdy = 1'b0;
    total++;
    if (l_dv !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", l_dv); end
  endtask

  task automatic test_right_gated();
    logic [9:0] bits;
    bits = 10'b0100000001;
    r_en = 1'b0; r_sin = 1'b0;
    tick(); tick();
    total++;
    if (r_busy !== 1'b0) begin bad++; $display("FAIL right_gated_idle got=%b exp=0", r_busy); end
    exp_q.push_back(8'h01);
    for (int i = 9; i >= 0; i--) begin
      r_sin = bits[i]; r_en = 1'b1;
      tick();
      r_en = 1'b0; r_sin = ~bits[i];
      tick(); tick();
    end
    exp_w = exp_q.pop_front();
    total++;
    if ({r_dv, r_dout} !== {1'b1, exp_w}) begin
      bad++; $display("FAIL right_data got=%b/%h exp=1/%h", r_dv, r_dout, exp_w);
    end
    total++;
    if (r_busy !== 1'b0) begin bad++; $display("FAIL right_busy got=%b exp=0", r_busy); end
    r_sin = 1'b1;
  endtask

  task automatic test_mid_reset();
    logic [4:0] part;
    send_l(8'h81, 1'b0, 1'b1, 1'b0);
    part = 5'b01010;
    for (int i = 4; i >= 0; i--) begin
      l_sin = part[i]; l_en = 1'b1;
      tick();
    end
    total++;
    if ({l_busy, l_dv} !== 2'b11) begin
      bad++; $display("FAIL midrst_pre got=%b exp=11", {l_busy, l_dv});
    end
    #2 aclr_n = 1'b0;
    #1;
    total++;
    if ({l_dout, l_dv, l_perr, l_ferr, l_ovr, l_busy} !== 13'h0) begin
      bad++; $display("FAIL midrst_async got=%h exp=0", {l_dout, l_dv, l_perr, l_ferr, l_ovr, l_busy});
    end
    tick();
    l_sin = 1'b1;
    aclr_n = 1'b1;
    tick();
    exp_q.push_back(8'hA5);
    send_l(8'hA5, 1'b0, 1'b1, 1'b0);
    exp_w = exp_q.pop_front();
    total++;
    if ({l_dv, l_dout} !== {1'b1, exp_w}) begin
      bad++; $display("FAIL midrst_after got=%b/%h exp=1/%h", l_dv, l_dout, exp_w);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_right_gated();
    test_mid_reset();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
